// File: rtl/dht11_poll_scheduler_pkg.sv
// Shared DHT11 definitions: scheduler state encoding, sample layout and default 50 MHz timing.
package dht11_poll_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_START   = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] hum;
        logic [7:0] temp;
    } sample_t;

    // Defaults at 50 MHz; START_LOW_CYC is the reader's 18 ms host start-low time.
    localparam int unsigned START_LOW_CYC   = 900_000;
    localparam int unsigned TIMEOUT_CYC_DEF = 1_500_000;
    localparam int unsigned MIN_GAP_CYC_DEF = 50_000_000;
    localparam int unsigned PERIOD_CYC_DEF  = 100_000_000;
    localparam int unsigned MAX_RETRY_DEF   = 3;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/dht11_poll_scheduler_if.sv
// Scheduler <-> reader datapath link: start/abort pulses out, done/result back.
interface dht11_poll_scheduler_if;
    logic       rd_start;
    logic       rd_abort;
    logic       rd_done;
    logic       rd_ok;
    logic [7:0] rd_hum;
    logic [7:0] rd_temp;

    modport master (output rd_start, rd_abort, input rd_done, rd_ok, rd_hum, rd_temp);
    modport slave  (input rd_start, rd_abort, output rd_done, rd_ok, rd_hum, rd_temp);
endinterface

// File: rtl/dht11_poll_scheduler_period_timer.sv
// Free-running 0..PERIOD_CYC-1 counter; tick is high in the wrap cycle, held at 0 while disabled.
module dht11_poll_scheduler_period_timer #(
    parameter int unsigned PERIOD_CYC = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(PERIOD_CYC) + 1;

    logic [W-1:0] cnt;
    logic         at_end;

    assign at_end = (cnt == W'(PERIOD_CYC - 1));
    assign tick   = en && at_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dht11_poll_scheduler.sv
// DHT11 read sequencer: triggers (periodic/on-demand), inter-read gap, per-attempt timeout,
// retries, and the last good humidity/temperature pair. Trigger->rd_start 2 cycles when gap met.
module dht11_poll_scheduler
    import dht11_poll_scheduler_pkg::*;
#(
    parameter int unsigned PERIOD_CYC  = PERIOD_CYC_DEF,
    parameter int unsigned MIN_GAP_CYC = MIN_GAP_CYC_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter int unsigned MAX_RETRY   = MAX_RETRY_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   auto_en,
    input  logic                   req,
    dht11_poll_scheduler_if.master rd,
    output logic [7:0]             humidity,
    output logic [7:0]             temperature,
    output logic                   sample_valid,
    output logic                   done,
    output logic                   error,
    output logic                   busy,
    output logic [7:0]             fail_count
);
    localparam int GW = $clog2(MIN_GAP_CYC) + 1;
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    localparam int RW = $clog2(MAX_RETRY) + 1;

    state_t        state;
    logic          pending;
    logic [GW-1:0] gap;
    logic [TW-1:0] tcnt;
    logic [RW-1:0] retry;
    sample_t       sample_q;
    logic          tick;
    logic          trig;
    logic          gap_met;
    logic          timeout;
    logic          attempt_end;

    dht11_poll_scheduler_period_timer #(.PERIOD_CYC(PERIOD_CYC)) u_period_timer (
        .clk   (clk),
        .reset (reset),
        .en    (auto_en),
        .tick  (tick)
    );

    assign trig        = tick || req;
    // START is entered on the edge that brings the gap count to MIN_GAP_CYC.
    assign gap_met     = (gap >= GW'(MIN_GAP_CYC - 1));
    assign timeout     = (state == ST_WAIT) && (tcnt == TW'(TIMEOUT_CYC - 1));
    assign attempt_end = (state == ST_WAIT) && (rd.rd_done || timeout);

    assign humidity    = sample_q.hum;
    assign temperature = sample_q.temp;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap <= '0;
        end else if (attempt_end) begin
            gap <= '0;
        end else if (gap != GW'(MIN_GAP_CYC)) begin
            gap <= gap + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            pending      <= 1'b0;
            tcnt         <= '0;
            retry        <= '0;
            sample_q     <= '0;
            sample_valid <= 1'b0;
            error        <= 1'b0;
            done         <= 1'b0;
            busy         <= 1'b0;
            fail_count   <= 8'd0;
            rd.rd_start  <= 1'b0;
            rd.rd_abort  <= 1'b0;
        end else begin
            rd.rd_start <= 1'b0;
            rd.rd_abort <= 1'b0;
            done        <= 1'b0;
            case (state)
                // Triggers arriving while busy are absorbed by the transaction in flight.
                ST_IDLE: begin
                    if (trig || pending) begin
                        pending <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_HOLDOFF;
                    end
                end
                ST_HOLDOFF: begin
                    if (gap_met) begin
                        pending     <= 1'b0;
                        rd.rd_start <= 1'b1;
                        state       <= ST_START;
                    end
                end
                ST_START: begin
                    // tcnt counts cycles elapsed since the rd_start cycle.
                    tcnt  <= TW'(1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    tcnt <= tcnt + 1'b1;
                    if (rd.rd_done && rd.rd_ok) begin
                        sample_q     <= '{hum: rd.rd_hum, temp: rd.rd_temp};
                        sample_valid <= 1'b1;
                        error        <= 1'b0;
                        done         <= 1'b1;
                        retry        <= '0;
                        busy         <= 1'b0;
                        state        <= ST_IDLE;
                    end else if (rd.rd_done || timeout) begin
                        rd.rd_abort <= !rd.rd_done;
                        fail_count  <= sat_inc8(fail_count);
                        if (retry < RW'(MAX_RETRY)) begin
                            retry <= retry + 1'b1;
                            state <= ST_HOLDOFF;
                        end else begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            retry <= '0;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Scoreboarded bench: a timeline model queues expected rd_start/rd_abort/done events, a monitor checks them.
module tb_dht11_poll_scheduler;
    localparam int PERIOD = 1000;
    localparam int GAP    = 200;
    localparam int TMO    = 100;
    localparam int MAXR   = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       auto_en = 1'b0;
    logic       req = 1'b0;
    logic [7:0] humidity, temperature, fail_count;
    logic       sample_valid, done, error, busy;

    dht11_poll_scheduler_if rif ();

    dht11_poll_scheduler #(
        .PERIOD_CYC (PERIOD),
        .MIN_GAP_CYC(GAP),
        .TIMEOUT_CYC(TMO),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .auto_en     (auto_en),
        .req         (req),
        .rd          (rif),
        .humidity    (humidity),
        .temperature (temperature),
        .sample_valid(sample_valid),
        .done        (done),
        .error       (error),
        .busy        (busy),
        .fail_count  (fail_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = good reply, 1 = checksum-bad reply, 2 = silent sensor
    typedef struct {
        int         kind;
        int         dly;
        logic [7:0] hum;
        logic [7:0] temp;
    } resp_t;

    typedef struct {
        int         cyc;
        logic [7:0] hum;
        logic [7:0] temp;
        int         fc;
        logic       err;
        logic       valid;
    } done_t;

    resp_t pl_q[$];
    resp_t script_q[$];
    int    exp_start_q[$];
    int    exp_abort_q[$];
    done_t exp_done_q[$];

    int         checks = 0;
    int         failures = 0;
    int         m_gap0, m_fc, m_first_start;
    logic [7:0] m_hum, m_temp;
    logic       m_valid, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int kind, input int dly, input logic [7:0] h, input logic [7:0] t);
        resp_t r;
        r.kind = kind;
        r.dly  = dly;
        r.hum  = h;
        r.temp = t;
        pl_q.push_back(r);
    endtask

    task automatic model_reset(input int c0);
        m_gap0  = c0;
        m_fc    = 0;
        m_hum   = 8'd0;
        m_temp  = 8'd0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // Whole-transaction timeline: a read may start once the trigger has propagated
    // (2 cycles) and GAP cycles have elapsed since the previous attempt ended.
    task automatic plan_txn(input int trig, output int endc);
        int    t;
        resp_t e;
        done_t d;
        t    = (trig + 2 > m_gap0 + GAP) ? trig + 2 : m_gap0 + GAP;
        endc = t;
        m_first_start = t;
        for (int i = 0; i <= MAXR; i++) begin
            e = pl_q.pop_front();
            script_q.push_back(e);
            exp_start_q.push_back(t);
            if (e.kind == 2) begin
                endc = t + TMO;
                exp_abort_q.push_back(endc);
            end else begin
                endc = t + e.dly + 1;
            end
            m_gap0 = endc;
            if (e.kind == 0) begin
                m_hum   = e.hum;
                m_temp  = e.temp;
                m_valid = 1'b1;
                m_err   = 1'b0;
            end else begin
                m_fc = (m_fc < 255) ? m_fc + 1 : 255;
                if (i == MAXR) m_err = 1'b1;
            end
            if (e.kind == 0 || i == MAXR) begin
                d.cyc = endc; d.hum = m_hum; d.temp = m_temp;
                d.fc = m_fc; d.err = m_err; d.valid = m_valid;
                exp_done_q.push_back(d);
                break;
            end
            t = endc + GAP;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic fire_req(input int at);
        wait_until(at);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic run_txn(input int trig);
        int endc;
        plan_txn(trig, endc);
        fire_req(trig);
        wait_until(endc + 2);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_humidity"}, humidity, 0);
        chk({tag, "_temperature"}, temperature, 0);
        chk({tag, "_sample_valid"}, sample_valid, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_fail_count"}, fail_count, 0);
        chk({tag, "_rd_start"}, rif.rd_start, 0);
        chk({tag, "_rd_abort"}, rif.rd_abort, 0);
    endtask

    // Reader model: answers each rd_start from the script queue.
    initial begin
        int    resp_at;
        resp_t cur;
        resp_at      = -1;
        rif.rd_done  = 1'b0;
        rif.rd_ok    = 1'b0;
        rif.rd_hum   = 8'd0;
        rif.rd_temp  = 8'd0;
        forever begin
            @(negedge clk);
            rif.rd_done = 1'b0;
            rif.rd_ok   = 1'($urandom);
            if (reset) begin
                resp_at = -1;
            end else begin
                if (resp_at == cyc) begin
                    rif.rd_done = 1'b1;
                    rif.rd_ok   = (cur.kind == 0);
                    rif.rd_hum  = cur.hum;
                    rif.rd_temp = cur.temp;
                    resp_at     = -1;
                end
                if (rif.rd_start === 1'b1 && script_q.size() > 0) begin
                    cur = script_q.pop_front();
                    if (cur.kind != 2) resp_at = cyc + cur.dly;
                end
            end
        end
    end

    // Monitor: every DUT event is matched against the next expected one.
    initial begin
        done_t d;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (rif.rd_start === 1'b1) begin
                    if (exp_start_q.size() == 0) chk("rd_start_unexpected", rif.rd_start, 0);
                    else chk("rd_start_cycle", cyc, exp_start_q.pop_front());
                end
                if (rif.rd_abort === 1'b1) begin
                    if (exp_abort_q.size() == 0) chk("rd_abort_unexpected", rif.rd_abort, 0);
                    else chk("rd_abort_cycle", cyc, exp_abort_q.pop_front());
                end
                if (done === 1'b1) begin
                    if (exp_done_q.size() == 0) begin
                        chk("done_unexpected", done, 0);
                    end else begin
                        d = exp_done_q.pop_front();
                        chk("done_cycle", cyc, d.cyc);
                        chk("done_humidity", humidity, d.hum);
                        chk("done_temperature", temperature, d.temp);
                        chk("done_fail_count", fail_count, d.fc);
                        chk("done_error", error, d.err);
                        chk("done_sample_valid", sample_valid, d.valid);
                        chk("done_busy", busy, 0);
                    end
                end
            end
        end
    end

    initial begin
        #(80000 * 10);
        checks++;
        failures++;
        $display("FAIL watchdog: cycle %0d reached, required the run to end earlier", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int c0, trig, t, nf, endc, tickc, a_cyc;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        c0 = cyc;
        model_reset(c0);

        // Power-up gap, then a good sample.
        add(0, $urandom_range(1, 98), 8'h37, 8'h19);
        plan_txn(c0 + 10, endc);
        wait_until(c0 + 10);
        chk("busy_before_req", busy, 0);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk("busy_after_req", busy, 1);
        wait_until(endc + 2);
        chk("idle_humidity", humidity, 8'h37);
        chk("idle_temperature", temperature, 8'h19);

        // Silent sensor on every attempt.
        repeat (3) add(2, 0, 8'($urandom), 8'($urandom));
        run_txn(cyc + 5);
        chk("after_timeout_error", error, 1);

        // One checksum failure then success.
        add(1, $urandom_range(1, 99), 8'($urandom), 8'($urandom));
        add(0, $urandom_range(1, 99), 8'($urandom), 8'($urandom));
        run_txn(cyc + 3);

        // rd_done on the last cycle before timeout still wins.
        add(1, 99, 8'($urandom), 8'($urandom));
        add(2, 0, 8'($urandom), 8'($urandom));
        add(0, 99, 8'($urandom), 8'($urandom));
        run_txn(cyc + 7);

        // Random mix of failures and successes.
        repeat (6) begin
            nf = $urandom_range(0, 3);
            for (int i = 0; i <= MAXR; i++) begin
                if (i < nf) begin
                    add($urandom_range(1, 2), $urandom_range(1, 99), 8'($urandom), 8'($urandom));
                end else begin
                    add(0, $urandom_range(1, 99), 8'($urandom), 8'($urandom));
                    break;
                end
            end
            run_txn(cyc + $urandom_range(1, 300));
        end

        // Periodic polling; a req during WAIT and a req coinciding with a tick add no read.
        a_cyc = cyc + 3;
        wait_until(a_cyc);
        auto_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tickc = a_cyc + PERIOD - 1 + PERIOD * k;
            add(0, $urandom_range(10, 90), 8'($urandom), 8'($urandom));
            plan_txn(tickc, endc);
            if (k == 2) fire_req(tickc);
            wait_until(m_first_start + 5);
            req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            wait_until(endc + 2);
        end
        auto_en = 1'b0;

        // Reset during WAIT abandons the transaction without a done pulse.
        trig = cyc + 4;
        t = (trig + 2 > m_gap0 + GAP) ? trig + 2 : m_gap0 + GAP;
        add(2, 0, 8'd0, 8'd0);
        script_q.push_back(pl_q.pop_front());
        exp_start_q.push_back(t);
        fire_req(trig);
        wait_until(t + 30);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midwait_reset");
        @(negedge clk);
        reset = 1'b0;
        c0 = cyc;
        model_reset(c0);
        chk("abort_after_reset", exp_abort_q.size(), 0);
        add(0, $urandom_range(1, 99), 8'($urandom), 8'($urandom));
        run_txn(c0 + 10);

        wait_until(cyc + 5);
        chk("pending_rd_start", exp_start_q.size(), 0);
        chk("pending_rd_abort", exp_abort_q.size(), 0);
        chk("pending_done", exp_done_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
